xilinx_rst_boot_conditioner: RTL and testbench



---
 rtl/xilinx_rst_boot_conditioner.sv | 120 ++++++++++++
 tb/tb_xilinx_rst_boot_conditioner.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/xilinx_rst_boot_conditioner.sv
// xilinx_rst_boot_conditioner
//   Sits between the board pins / clock wizard and gr_heep_top. The system is
//   held in reset until the clock wizard reports lock and both boot straps
//   have held still for SETTLE_CYCLES consecutive cycles. On release the
//   strap values are frozen and passed to the core. If lock is lost while
//   running, reset is asserted again and the loss is counted for debug.
//
// Ports
//   clk_i                : clock from the clock wizard
//   rst_ni               : async active-low board reset (deassertion assumed
//                          synchronous to clk_i)
//   pll_locked_i         : clock wizard lock, asynchronous
//   boot_select_i        : raw strap pin, asynchronous
//   execute_from_flash_i : raw strap pin, asynchronous
//   rst_no               : conditioned active-low reset, registered
//   boot_select_o        : boot_select strap frozen at reset release
//   execute_from_flash_o : execute_from_flash strap frozen at reset release
//   lock_lost_cnt_o      : saturating count of RUN -> WAIT_LOCK exits
module xilinx_rst_boot_conditioner #(
    parameter int SYNC_STAGES   = 2,
    parameter int SETTLE_CYCLES = 16
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       pll_locked_i,
    input  logic       boot_select_i,
    input  logic       execute_from_flash_i,
    output logic       rst_no,
    output logic       boot_select_o,
    output logic       execute_from_flash_o,
    output logic [7:0] lock_lost_cnt_o
);

    localparam int            CW       = $clog2(SETTLE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(SETTLE_CYCLES - 1);

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        SETTLE    = 2'd1,
        RUN       = 2'd2
    } state_t;

    // Three synchroniser lanes packed per stage: {lock, boot_select, eff}.
    logic [SYNC_STAGES-1:0][2:0] sync_q;
    logic                        locked_s;
    logic [1:0]                  straps_s;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [1:0]    strap_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= '0;
        end else begin
            sync_q[0] <= {pll_locked_i, boot_select_i, execute_from_flash_i};
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    assign locked_s = sync_q[SYNC_STAGES-1][2];
    assign straps_s = sync_q[SYNC_STAGES-1][1:0];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state                <= WAIT_LOCK;
            cnt                  <= '0;
            strap_q              <= '0;
            rst_no               <= 1'b0;
            boot_select_o        <= 1'b0;
            execute_from_flash_o <= 1'b0;
            lock_lost_cnt_o      <= '0;
        end else begin
            case (state)
                WAIT_LOCK: begin
                    cnt <= '0;
                    if (locked_s) begin
                        state   <= SETTLE;
                        strap_q <= straps_s;
                    end
                end
                SETTLE: begin
                    // strap_q always tracks the previous cycle's straps so any
                    // edge on either pin is caught as a mismatch.
                    strap_q <= straps_s;
                    if (!locked_s) begin
                        state <= WAIT_LOCK;
                        cnt   <= '0;
                    end else if (straps_s != strap_q) begin
                        // A strap change beats the terminal count.
                        cnt <= '0;
                    end else if (cnt == CNT_LAST) begin
                        state                <= RUN;
                        boot_select_o        <= straps_s[1];
                        execute_from_flash_o <= straps_s[0];
                        rst_no               <= 1'b1;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                RUN: begin
                    if (!locked_s) begin
                        state  <= WAIT_LOCK;
                        rst_no <= 1'b0;
                        if (lock_lost_cnt_o != 8'hFF) begin
                            lock_lost_cnt_o <= lock_lost_cnt_o + 8'd1;
                        end
                    end
                end
                default: begin
                    state  <= WAIT_LOCK;
                    rst_no <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_xilinx_rst_boot_conditioner.sv
// Directed bench for xilinx_rst_boot_conditioner with default parameters.
// Inputs change right after a falling edge; outputs are sampled on falling
// edges. Latencies are counted in rising edges, starting with the first edge
// that samples the changed input.
module tb_xilinx_rst_boot_conditioner;

    logic       clk_i = 1'b0;
    logic       rst_ni = 1'b0;
    logic       pll_locked_i = 1'b0;
    logic       boot_select_i = 1'b0;
    logic       execute_from_flash_i = 1'b0;
    logic       rst_no;
    logic       boot_select_o;
    logic       execute_from_flash_o;
    logic [7:0] lock_lost_cnt_o;

    int checks = 0;
    int errors = 0;

    always #5 clk_i = ~clk_i;

    xilinx_rst_boot_conditioner #(.SYNC_STAGES(2), .SETTLE_CYCLES(16)) dut (
        .clk_i                (clk_i),
        .rst_ni               (rst_ni),
        .pll_locked_i         (pll_locked_i),
        .boot_select_i        (boot_select_i),
        .execute_from_flash_i (execute_from_flash_i),
        .rst_no               (rst_no),
        .boot_select_o        (boot_select_o),
        .execute_from_flash_o (execute_from_flash_o),
        .lock_lost_cnt_o      (lock_lost_cnt_o)
    );

    typedef struct {
        logic bs;
        logic eff;
        logic exp_bs;
        logic exp_eff;
        int   exp_lat;
    } vec_t;

    vec_t tbl[4];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Raise lock and count edges until rst_no rises. Optionally toggles
    // boot_select_i after edge n for n in [first, last] stepping by period.
    // Returns -1 on timeout.
    task automatic lock_and_release(input int first, input int last, input int period,
                                    output int n);
        bit done;
        done = 1'b0;
        n = 0;
        pll_locked_i = 1'b1;
        while (!done && n < 200) begin
            @(negedge clk_i);
            n++;
            if (rst_no) done = 1'b1;
            else if (first != 0 && n >= first && n <= last && ((n - first) % period) == 0)
                boot_select_i = ~boot_select_i;
        end
        if (!done) n = -1;
    endtask

    // Drop lock and count edges until rst_no falls; -1 on timeout.
    task automatic drop_and_fall(output int n);
        bit done;
        done = 1'b0;
        n = 0;
        pll_locked_i = 1'b0;
        while (!done && n < 50) begin
            @(negedge clk_i);
            n++;
            if (!rst_no) done = 1'b1;
        end
        if (!done) n = -1;
    endtask

    task automatic do_reset();
        @(negedge clk_i);
        rst_ni = 1'b0;
        pll_locked_i = 1'b0;
        repeat (3) @(negedge clk_i);
        rst_ni = 1'b1;
        repeat (4) @(negedge clk_i);
    endtask

    // Watch rst_no for a number of cycles and report whether it ever rose.
    task automatic watch_low(input int cycles, output int seen);
        seen = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk_i);
            if (rst_no) seen = 1;
        end
    endtask

    initial begin
        int lat;
        int seen;

        tbl[0] = '{bs: 1'b1, eff: 1'b0, exp_bs: 1'b1, exp_eff: 1'b0, exp_lat: 19};
        tbl[1] = '{bs: 1'b0, eff: 1'b1, exp_bs: 1'b0, exp_eff: 1'b1, exp_lat: 19};
        tbl[2] = '{bs: 1'b0, eff: 1'b0, exp_bs: 1'b0, exp_eff: 1'b0, exp_lat: 19};
        tbl[3] = '{bs: 1'b1, eff: 1'b1, exp_bs: 1'b1, exp_eff: 1'b1, exp_lat: 19};

        // Reset state
        #12;
        chk("reset_rst_no", int'(rst_no), 0);
        chk("reset_bs", int'(boot_select_o), 0);
        chk("reset_eff", int'(execute_from_flash_o), 0);
        chk("reset_cnt", int'(lock_lost_cnt_o), 0);

        // Basic release for every strap combination
        for (int i = 0; i < 4; i++) begin
            boot_select_i = tbl[i].bs;
            execute_from_flash_i = tbl[i].eff;
            do_reset();
            chk($sformatf("vec%0d_pre_rst_no", i), int'(rst_no), 0);
            lock_and_release(0, 0, 1, lat);
            chk($sformatf("vec%0d_latency", i), lat, tbl[i].exp_lat);
            chk($sformatf("vec%0d_bs", i), int'(boot_select_o), int'(tbl[i].exp_bs));
            chk($sformatf("vec%0d_eff", i), int'(execute_from_flash_o), int'(tbl[i].exp_eff));
            chk($sformatf("vec%0d_lost", i), int'(lock_lost_cnt_o), 0);
        end

        // Strap freeze in RUN (currently {1,1})
        boot_select_i = 1'b0;
        execute_from_flash_i = 1'b0;
        watch_low(20, seen);
        chk("freeze_rst_no", int'(rst_no), 1);
        chk("freeze_bs", int'(boot_select_o), 1);
        chk("freeze_eff", int'(execute_from_flash_o), 1);
        drop_and_fall(lat);
        chk("freeze_fall_latency", lat, 3);
        chk("freeze_lost", int'(lock_lost_cnt_o), 1);
        chk("freeze_hold_bs", int'(boot_select_o), 1);
        repeat (3) @(negedge clk_i);
        lock_and_release(0, 0, 1, lat);
        chk("freeze_relock_latency", lat, 19);
        chk("freeze_new_bs", int'(boot_select_o), 0);
        chk("freeze_new_eff", int'(execute_from_flash_o), 0);

        // Repeated lock loss: 3-cycle drops, counter saturates
        boot_select_i = 1'b1;
        execute_from_flash_i = 1'b1;
        for (int k = 0; k < 300; k++) begin
            drop_and_fall(lat);
            chk("loop_fall_latency", lat, 3);
            lock_and_release(0, 0, 1, lat);
            chk("loop_release_latency", lat, 19);
            if (k == 253) chk("loop_lost_255", int'(lock_lost_cnt_o), 255);
        end
        chk("loop_lost_sat", int'(lock_lost_cnt_o), 255);
        chk("loop_bs", int'(boot_select_o), 1);
        chk("loop_eff", int'(execute_from_flash_o), 1);

        // Async reset mid-SETTLE (cnt = 10 after the 13th edge)
        drop_and_fall(lat);
        repeat (5) @(negedge clk_i);
        pll_locked_i = 1'b1;
        repeat (13) @(negedge clk_i);
        #2 rst_ni = 1'b0;
        #1;
        chk("async_rst_no", int'(rst_no), 0);
        chk("async_bs", int'(boot_select_o), 0);
        chk("async_eff", int'(execute_from_flash_o), 0);
        chk("async_lost", int'(lock_lost_cnt_o), 0);
        repeat (2) @(negedge clk_i);
        rst_ni = 1'b1;
        lock_and_release(0, 0, 1, lat);
        chk("async_release_latency", lat, 19);

        // Lock glitch of 10 cycles never releases reset
        do_reset();
        pll_locked_i = 1'b1;
        repeat (10) @(negedge clk_i);
        pll_locked_i = 1'b0;
        watch_low(40, seen);
        chk("glitch_never_high", seen, 0);
        chk("glitch_lost", int'(lock_lost_cnt_o), 0);
        lock_and_release(0, 0, 1, lat);
        chk("glitch_relock_latency", lat, 19);

        // Lock loss coinciding with the terminal count
        do_reset();
        pll_locked_i = 1'b1;
        repeat (16) @(negedge clk_i);
        pll_locked_i = 1'b0;
        watch_low(30, seen);
        chk("term_lock_never_high", seen, 0);
        chk("term_lock_lost", int'(lock_lost_cnt_o), 0);
        lock_and_release(0, 0, 1, lat);
        chk("term_lock_relock_latency", lat, 19);

        // Strap change coinciding with the terminal count: restart wins
        boot_select_i = 1'b0;
        execute_from_flash_i = 1'b1;
        do_reset();
        lock_and_release(16, 16, 1, lat);
        chk("term_strap_latency", lat, 35);
        chk("term_strap_bs", int'(boot_select_o), 1);
        chk("term_strap_eff", int'(execute_from_flash_o), 1);

        // Bouncing strap: toggles after edges 5..35, final value 1
        boot_select_i = 1'b0;
        execute_from_flash_i = 1'b0;
        do_reset();
        lock_and_release(5, 35, 5, lat);
        chk("bounce_latency", lat, 54);
        chk("bounce_bs", int'(boot_select_o), 1);
        chk("bounce_eff", int'(execute_from_flash_o), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
